// File: rtl/ads1675_serial_source_model_if.sv
// Serial ADC source bundle: run enable and sample in, bit clock / frame marker / data out.
interface ads1675_serial_source_model_if #(
    parameter int DATA_W = 24
);
    logic                     en;
    logic signed [DATA_W-1:0] data;
    logic                     sclk;
    logic                     drdy;
    logic                     dout;

    // The source model drives the serial lines; the environment supplies en/data.
    modport master (
        input  en,
        input  data,
        output sclk,
        output drdy,
        output dout
    );

    modport slave (
        output en,
        output data,
        input  sclk,
        input  drdy,
        input  dout
    );
endinterface

// File: rtl/ads1675_serial_source_model.sv
// ADS1675-style serial source: divides aclk into sclk and sends one DATA_W-bit sample
// per FRAME_SCLKS-slot frame, MSB first, with a one-sclk drdy marker on slot 0.
module ads1675_serial_source_model #(
    parameter int SCLK_HALF   = 2,
    parameter int FRAME_SCLKS = 32,
    parameter int DATA_W      = 24
) (
    input  logic aclk,
    input  logic aresetn,
    ads1675_serial_source_model_if.master bus
);

    localparam int DIV_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int SLOT_W = $clog2(FRAME_SCLKS);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_HALF - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_SCLKS - 1);

    logic [DIV_W-1:0]  div_cnt,  div_nxt;
    logic [SLOT_W-1:0] slot,     slot_nxt;
    logic [SLOT_W-1:0] slot_wrap;
    logic [DATA_W-1:0] shreg,    shreg_nxt;
    logic              sclk_r,   sclk_nxt;
    logic              drdy_r,   drdy_nxt;
    logic              dout_r,   dout_nxt;
    logic              tick;
    logic              fall;

    assign tick      = (div_cnt == DIV_LAST);
    assign fall      = tick && sclk_r;
    assign slot_wrap = (slot == SLOT_LAST) ? '0 : slot + 1'b1;

    always_comb begin
        div_nxt   = div_cnt;
        sclk_nxt  = sclk_r;
        slot_nxt  = slot;
        shreg_nxt = shreg;
        drdy_nxt  = drdy_r;
        dout_nxt  = dout_r;

        if (!bus.en) begin
            // Disabled: everything parks at its reset value, abandoning any frame.
            div_nxt   = '0;
            sclk_nxt  = 1'b0;
            slot_nxt  = SLOT_LAST;
            shreg_nxt = '0;
            drdy_nxt  = 1'b0;
            dout_nxt  = 1'b0;
        end else begin
            if (tick) begin
                div_nxt  = '0;
                sclk_nxt = ~sclk_r;
            end else begin
                div_nxt  = div_cnt + 1'b1;
            end

            // All serial updates ride the falling toggle so they are settled by the next rise.
            if (fall) begin
                slot_nxt = slot_wrap;
                if (slot_wrap == '0) begin
                    shreg_nxt = bus.data;
                    dout_nxt  = bus.data[DATA_W-1];
                    drdy_nxt  = 1'b1;
                end else begin
                    drdy_nxt = 1'b0;
                    if (int'(slot_wrap) < DATA_W) begin
                        // Rotate so the next bit to send sits just below the MSB.
                        shreg_nxt = {shreg[DATA_W-2:0], shreg[DATA_W-1]};
                        dout_nxt  = shreg[DATA_W-2];
                    end else begin
                        dout_nxt  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            div_cnt <= '0;
            sclk_r  <= 1'b0;
            slot    <= SLOT_LAST;
            shreg   <= '0;
            drdy_r  <= 1'b0;
            dout_r  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            sclk_r  <= sclk_nxt;
            slot    <= slot_nxt;
            shreg   <= shreg_nxt;
            drdy_r  <= drdy_nxt;
            dout_r  <= dout_nxt;
        end
    end

    assign bus.sclk = sclk_r;
    assign bus.drdy = drdy_r;
    assign bus.dout = dout_r;

`ifndef SYNTHESIS
    a_drdy_slot0 : assert property (@(posedge aclk) disable iff (!aresetn)
        drdy_r |-> (slot == '0));
    a_div_range : assert property (@(posedge aclk) disable iff (!aresetn)
        div_cnt <= DIV_LAST);
`endif

endmodule

// File: tb/tb_ads1675_serial_source_model.sv
// Bench: scoreboarded frame deserializer on the default instance plus a frame-period sweep.
module tb_ads1675_serial_source_model;

    localparam int DW    = 24;
    localparam int FRAME = 32;

    logic aclk;
    logic aresetn;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rx_on    = 1'b1;
    bit mon_on   = 1'b1;

    logic [DW-1:0] sb[$];

    ads1675_serial_source_model_if #(.DATA_W(DW)) bus ();

    ads1675_serial_source_model #(
        .SCLK_HALF   (2),
        .FRAME_SCLKS (FRAME),
        .DATA_W      (DW)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(negedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // drdy period/width on the default instance
    logic drdy_q = 1'b0;
    int   last_rise = -1;
    always @(negedge aclk) begin
        drdy_q <= bus.drdy;
        if (!mon_on) begin
            last_rise <= -1;
        end else begin
            if (bus.drdy && !drdy_q) begin
                if (last_rise >= 0) check("drdy_period", cyc - last_rise, 128);
                last_rise <= cyc;
            end
            if (!bus.drdy && drdy_q && last_rise >= 0)
                check("drdy_width", cyc - last_rise, 4);
        end
    end

    // Receiver: samples on each sclk rise, compares the word against the scoreboard
    logic          sclk_q = 1'b0;
    int            rx_cnt = 0;
    logic [DW-1:0] rx_word = '0;
    bit            frame_ok = 1'b1;
    always @(negedge aclk) begin
        sclk_q <= bus.sclk;
        if (!rx_on || !aresetn) begin
            rx_cnt <= 0;
        end else if (bus.sclk && !sclk_q) begin
            if (bus.drdy) begin
                rx_word  <= {{(DW-1){1'b0}}, bus.dout};
                rx_cnt   <= 1;
                frame_ok <= 1'b1;
            end else if (rx_cnt > 0) begin
                rx_cnt <= (rx_cnt == FRAME - 1) ? 0 : rx_cnt + 1;
                if (rx_cnt < DW) rx_word <= {rx_word[DW-2:0], bus.dout};
                else if (bus.dout !== 1'b0) frame_ok <= 1'b0;
                if (rx_cnt == DW - 1) begin
                    if (sb.size() == 0) check("sb_underflow", 1, 0);
                    else check("frame_word", {rx_word[DW-2:0], bus.dout}, sb.pop_front());
                end
                if (rx_cnt == FRAME - 1)
                    check("frame_tail", (frame_ok && bus.dout === 1'b0) ? 1 : 0, 1);
            end
        end
    end

    // Parameter sweep: first frame start, period and drdy width per configuration
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int SH  = (g % 2 == 1) ? 3 : 1;
        localparam int FS  = (g < 2) ? 24 : 48;
        localparam int PER = 2 * SH * FS;

        ads1675_serial_source_model_if #(.DATA_W(DW)) sw_if ();
        assign sw_if.en   = 1'b1;
        assign sw_if.data = 24'h000000;

        ads1675_serial_source_model #(
            .SCLK_HALF   (SH),
            .FRAME_SCLKS (FS),
            .DATA_W      (DW)
        ) u_sw (
            .aclk    (aclk),
            .aresetn (aresetn),
            .bus     (sw_if)
        );

        logic dq = 1'b0;
        int   since = 0, last = -1, nper = 0, nw = 0;
        bit   first_done = 1'b0;
        always @(negedge aclk) begin
            dq <= sw_if.drdy;
            if (!aresetn) begin
                since <= 0;
                last  <= -1;
            end else begin
                since <= since + 1;
                if (sw_if.drdy && !dq) begin
                    if (!first_done) begin
                        check($sformatf("sw%0d_first", g), since + 1, 2 * SH);
                        first_done <= 1'b1;
                    end
                    if (last >= 0 && nper < 3) begin
                        check($sformatf("sw%0d_period", g), since - last, PER);
                        nper <= nper + 1;
                    end
                    last <= since;
                end
                if (!sw_if.drdy && dq && last >= 0 && nw < 2) begin
                    check($sformatf("sw%0d_width", g), since - last, 2 * SH);
                    nw <= nw + 1;
                end
            end
        end
    end

    task automatic wait_drdy(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (bus.drdy !== lvl && n < budget) begin
            @(negedge aclk);
            n++;
        end
        if (bus.drdy !== lvl) check(tag, bus.drdy, lvl);
    endtask

    // New sample applied as drdy drops; it belongs to the following frame.
    task automatic next_frame(input logic [DW-1:0] val);
        wait_drdy(1'b1, 300, "wait_drdy_rise");
        wait_drdy(1'b0, 300, "wait_drdy_fall");
        bus.data = val;
        sb.push_back(val);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        aresetn  = 1'b0;
        bus.en   = 1'b1;
        bus.data = '0;
        repeat (3) @(negedge aclk);
        check("reset_outs", {bus.sclk, bus.drdy, bus.dout}, 3'b000);

        sb.push_back(24'h000000);
        #2 aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        check("first_rise", {bus.sclk, bus.drdy}, 2'b10);
        @(negedge aclk);
        check("first_frame", {bus.sclk, bus.drdy, bus.dout}, 3'b010);

        next_frame(24'hA5F00F);
        next_frame(24'h123456);
        next_frame(24'h800000);
        next_frame(24'h7FFFFF);
        repeat (100) next_frame(24'($urandom()));

        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge aclk);
            n++;
        end
        if (sb.size() != 0) check("sb_drain", sb.size(), 0);

        // Drop en mid-frame while sclk and dout are both high
        rx_on    = 1'b0;
        mon_on   = 1'b0;
        bus.data = 24'hFFFFFF;
        wait_drdy(1'b1, 300, "wait_en_frame");
        repeat (42) @(negedge aclk);
        check("en_pre", {bus.sclk, bus.drdy, bus.dout}, 3'b101);
        bus.en = 1'b0;
        @(negedge aclk);
        check("en_drop", {bus.sclk, bus.drdy, bus.dout}, 3'b000);
        repeat (5) @(negedge aclk);
        check("en_hold", {bus.sclk, bus.drdy, bus.dout}, 3'b000);
        bus.en = 1'b1;
        repeat (3) @(negedge aclk);
        check("en_rise", {bus.sclk, bus.drdy}, 2'b10);
        @(negedge aclk);
        check("en_restart", {bus.sclk, bus.drdy, bus.dout}, 3'b011);

        // Asynchronous reset during sclk high at slot 5
        repeat (22) @(negedge aclk);
        check("areset_pre", {bus.sclk, bus.drdy, bus.dout}, 3'b101);
        #2 aresetn = 1'b0;
        #1 check("areset_async", {bus.sclk, bus.drdy, bus.dout}, 3'b000);
        repeat (3) @(negedge aclk);
        check("areset_hold", {bus.sclk, bus.drdy, bus.dout}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
